// File: rtl/tomasulo_pkg.sv
// Shared types and sizing for the Tomasulo back end: RS entry layout, CDB geometry.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package tomasulo_pkg;

    localparam int no_RS_addsublog = 8;
    localparam int CDB_W           = 3;
    localparam int TAG_W           = 5;
    localparam int XLEN            = 32;
    localparam int ALUOP_W         = 4;

    // One add/sub/logic reservation-station slot. Qx_valid=1 means the
    // operand is still outstanding and Vx is meaningless until tag Qx
    // appears on the CDB.
    typedef struct packed {
        logic               busy;
        logic               ready;
        logic [TAG_W-1:0]   ROB_index;
        logic [ALUOP_W-1:0] alu_op;
        logic               Qj_valid;
        logic [TAG_W-1:0]   Qj;
        logic               Qk_valid;
        logic [TAG_W-1:0]   Qk;
        logic [XLEN-1:0]    Vj;
        logic [XLEN-1:0]    Vk;
    } AddSub_RS_Entry_t;

endpackage

// File: rtl/rs_cdb_match.sv
// CDB snoop for one operand tag: reports whether any valid bus carries the tag and its data.
// Latency: purely combinational.
// Backpressure: none; lowest-indexed matching bus wins if several match.
//   tag_i       operand tag being waited on
//   cdb_*_i     all CDB buses (valid/tag/data)
//   hit_o/data_o  match flag and the winning bus's result value
module rs_cdb_match
    import tomasulo_pkg::*;
(
    input  logic [TAG_W-1:0]            tag_i,
    input  logic [CDB_W-1:0]            cdb_valid_i,
    input  logic [CDB_W-1:0][TAG_W-1:0] cdb_tag_i,
    input  logic [CDB_W-1:0][XLEN-1:0]  cdb_data_i,
    output logic                        hit_o,
    output logic [XLEN-1:0]             data_o
);

    // Scan from the top bus down so the lowest matching index is the last
    // assignment and therefore wins.
    always_comb begin
        hit_o  = 1'b0;
        data_o = '0;
        for (int b = CDB_W - 1; b >= 0; b--) begin
            if (cdb_valid_i[b] && (cdb_tag_i[b] == tag_i)) begin
                hit_o  = 1'b1;
                data_o = cdb_data_i[b];
            end
        end
    end

endmodule

// File: rtl/addsub_rs_bank.sv
// Reservation-station bank for the add/sub/logic ALUs: allocate, CDB wakeup, issue clear, flush.
// Latency: allocation/wakeup/clear visible on rs_out and free_cnt one edge later.
// Backpressure: disp_stall (comb) when valid requests exceed free entries; nothing is allocated.
//   clk/rst/flush   clock, sync active-high reset, mispredict flush
//   disp_*          dispatch requests (contiguous from slot 0) and stall back to dispatch
//   cdb_*           CDB buses snooped for wakeup
//   rs_clear        per-entry dealloc from the issue stage
//   rs_out/free_cnt registered entry array and free-entry count
module addsub_rs_bank
    import tomasulo_pkg::*;
#(
    parameter  int NUM_RS     = no_RS_addsublog,
    parameter  int DISPATCH_W = 3,
    localparam int CNT_W      = $clog2(NUM_RS) + 1
)(
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                flush,
    input  logic [DISPATCH_W-1:0]               disp_valid,
    input  AddSub_RS_Entry_t [DISPATCH_W-1:0]   disp_entry,
    output logic                                disp_stall,
    input  logic [CDB_W-1:0]                    cdb_valid,
    input  logic [CDB_W-1:0][TAG_W-1:0]         cdb_tag,
    input  logic [CDB_W-1:0][XLEN-1:0]          cdb_data,
    input  logic [NUM_RS-1:0]                   rs_clear,
    output AddSub_RS_Entry_t [NUM_RS-1:0]       rs_out,
    output logic [CNT_W-1:0]                    free_cnt
);

    localparam int SLOT_W = $clog2(DISPATCH_W + 1);

    AddSub_RS_Entry_t [NUM_RS-1:0]       rs_q, rs_d;
    logic [CNT_W-1:0]                    free_cnt_q, free_cnt_d;
    logic [NUM_RS-1:0]                   busy_q;
    logic [CNT_W-1:0]                    req_cnt;
    logic                                alloc_go;
    logic [NUM_RS-1:0]                   alloc_en;
    logic [NUM_RS-1:0][SLOT_W-1:0]       alloc_slot;
    logic [NUM_RS-1:0]                   hit_j, hit_k;
    logic [NUM_RS-1:0][XLEN-1:0]         data_j, data_k;
    logic [DISPATCH_W-1:0]               dhit_j, dhit_k;
    logic [DISPATCH_W-1:0][XLEN-1:0]     ddata_j, ddata_k;
    logic                                cdb_dup;

    // CDB snoop for resident entries and for the ops being dispatched now,
    // so an operand produced in the allocation cycle is never missed.
    for (genvar e = 0; e < NUM_RS; e++) begin : g_ent
        assign busy_q[e] = rs_q[e].busy;
        rs_cdb_match u_match_j (
            .tag_i(rs_q[e].Qj), .cdb_valid_i(cdb_valid), .cdb_tag_i(cdb_tag),
            .cdb_data_i(cdb_data), .hit_o(hit_j[e]), .data_o(data_j[e])
        );
        rs_cdb_match u_match_k (
            .tag_i(rs_q[e].Qk), .cdb_valid_i(cdb_valid), .cdb_tag_i(cdb_tag),
            .cdb_data_i(cdb_data), .hit_o(hit_k[e]), .data_o(data_k[e])
        );
    end

    for (genvar s = 0; s < DISPATCH_W; s++) begin : g_disp
        rs_cdb_match u_match_j (
            .tag_i(disp_entry[s].Qj), .cdb_valid_i(cdb_valid), .cdb_tag_i(cdb_tag),
            .cdb_data_i(cdb_data), .hit_o(dhit_j[s]), .data_o(ddata_j[s])
        );
        rs_cdb_match u_match_k (
            .tag_i(disp_entry[s].Qk), .cdb_valid_i(cdb_valid), .cdb_tag_i(cdb_tag),
            .cdb_data_i(cdb_data), .hit_o(dhit_k[s]), .data_o(ddata_k[s])
        );
    end

    // Capacity is judged on registered state only: an entry freed by
    // rs_clear this cycle is not offered until the next one.
    always_comb begin
        req_cnt = '0;
        for (int s = 0; s < DISPATCH_W; s++) begin
            req_cnt = req_cnt + CNT_W'(disp_valid[s]);
        end
    end

    assign disp_stall = (req_cnt > free_cnt_q);
    assign alloc_go   = !disp_stall && !flush;

    // Prefix scan: the n-th free entry (by index) takes dispatch slot n.
    always_comb begin
        logic [SLOT_W-1:0] nxt;
        alloc_en   = '0;
        alloc_slot = '0;
        nxt        = '0;
        for (int e = 0; e < NUM_RS; e++) begin
            if (!busy_q[e] && (nxt < SLOT_W'(DISPATCH_W))) begin
                if (alloc_go && disp_valid[nxt]) begin
                    alloc_en[e]   = 1'b1;
                    alloc_slot[e] = nxt;
                end
                nxt = nxt + SLOT_W'(1);
            end
        end
    end

    // Per-entry next state. Later assignments override earlier ones, so the
    // order below encodes priority: flush > clear > allocate > wakeup.
    always_comb begin
        free_cnt_d = CNT_W'(NUM_RS);
        for (int e = 0; e < NUM_RS; e++) begin
            rs_d[e] = rs_q[e];
            if (rs_q[e].busy) begin
                if (rs_q[e].Qj_valid && hit_j[e]) begin
                    rs_d[e].Vj       = data_j[e];
                    rs_d[e].Qj_valid = 1'b0;
                end
                if (rs_q[e].Qk_valid && hit_k[e]) begin
                    rs_d[e].Vk       = data_k[e];
                    rs_d[e].Qk_valid = 1'b0;
                end
            end
            if (alloc_en[e]) begin
                rs_d[e]      = disp_entry[alloc_slot[e]];
                rs_d[e].busy = 1'b1;
                if (disp_entry[alloc_slot[e]].Qj_valid && dhit_j[alloc_slot[e]]) begin
                    rs_d[e].Vj       = ddata_j[alloc_slot[e]];
                    rs_d[e].Qj_valid = 1'b0;
                end
                if (disp_entry[alloc_slot[e]].Qk_valid && dhit_k[alloc_slot[e]]) begin
                    rs_d[e].Vk       = ddata_k[alloc_slot[e]];
                    rs_d[e].Qk_valid = 1'b0;
                end
            end
            // Clearing a non-busy entry is illegal; ignoring it keeps a
            // same-cycle allocation into that entry intact.
            if (rs_clear[e] && rs_q[e].busy) begin
                rs_d[e].busy = 1'b0;
            end
            rs_d[e].ready = rs_d[e].busy && !rs_d[e].Qj_valid && !rs_d[e].Qk_valid;
            if (flush) begin
                rs_d[e] = '0;
            end
        end
        for (int e = 0; e < NUM_RS; e++) begin
            if (rs_d[e].busy) begin
                free_cnt_d = free_cnt_d - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rs_q       <= '0;
            free_cnt_q <= CNT_W'(NUM_RS);
        end else begin
            rs_q       <= rs_d;
            free_cnt_q <= free_cnt_d;
        end
    end

    assign rs_out   = rs_q;
    assign free_cnt = free_cnt_q;

    always_comb begin
        cdb_dup = 1'b0;
        for (int a = 0; a < CDB_W; a++) begin
            for (int b = a + 1; b < CDB_W; b++) begin
                if (cdb_valid[a] && cdb_valid[b] && (cdb_tag[a] == cdb_tag[b])) begin
                    cdb_dup = 1'b1;
                end
            end
        end
    end

    a_clear_only_busy: assert property (@(posedge clk) disable iff (rst)
        (rs_clear & ~busy_q) == '0);
    a_cdb_tags_unique: assert property (@(posedge clk) disable iff (rst)
        !cdb_dup);

endmodule

// File: tb/tb_addsub_rs_bank.sv
module tb_addsub_rs_bank;
    import tomasulo_pkg::*;

    localparam int NRS = 8;
    localparam int DW  = 3;
    localparam int EW  = $bits(AddSub_RS_Entry_t);

    logic                              clk;
    logic                              rst;
    logic                              flush;
    logic [DW-1:0]                     disp_valid;
    AddSub_RS_Entry_t [DW-1:0]         disp_entry;
    logic                              disp_stall;
    logic [CDB_W-1:0]                  cdb_valid;
    logic [CDB_W-1:0][TAG_W-1:0]       cdb_tag;
    logic [CDB_W-1:0][XLEN-1:0]        cdb_data;
    logic [NRS-1:0]                    rs_clear;
    AddSub_RS_Entry_t [NRS-1:0]        rs_out;
    logic [3:0]                        free_cnt;

    addsub_rs_bank #(.NUM_RS(NRS), .DISPATCH_W(DW)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .disp_valid(disp_valid), .disp_entry(disp_entry), .disp_stall(disp_stall),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
        .rs_clear(rs_clear), .rs_out(rs_out), .free_cnt(free_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference state: what each entry must hold after the last edge.
    AddSub_RS_Entry_t m [NRS];

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: dut=%0h expected=%0h", nm, act, exp);
        end
    endtask

    function automatic AddSub_RS_Entry_t mk(input logic [4:0] rob, input logic qjv,
                                            input logic [4:0] qj, input logic qkv,
                                            input logic [4:0] qk, input logic [31:0] vj,
                                            input logic [31:0] vk);
        AddSub_RS_Entry_t x;
        x           = '0;
        x.busy      = 1'b0;   // dispatch's busy/ready are junk and must be ignored
        x.ready     = 1'b1;
        x.ROB_index = rob;
        x.alu_op    = rob[3:0];
        x.Qj_valid  = qjv;
        x.Qj        = qj;
        x.Qk_valid  = qkv;
        x.Qk        = qk;
        x.Vj        = vj;
        x.Vk        = vk;
        return x;
    endfunction

    // Result of the CDB for a tag: bit 32 = found, lowest bus wins.
    function automatic logic [32:0] cdb_lookup(input logic [4:0] t);
        for (int b = 0; b < CDB_W; b++) begin
            if (cdb_valid[b] && cdb_tag[b] == t) return {1'b1, cdb_data[b]};
        end
        return 33'd0;
    endfunction

    function automatic AddSub_RS_Entry_t wake(input AddSub_RS_Entry_t x);
        logic [32:0] r;
        r = cdb_lookup(x.Qj);
        if (x.Qj_valid && r[32]) begin x.Vj = r[31:0]; x.Qj_valid = 1'b0; end
        r = cdb_lookup(x.Qk);
        if (x.Qk_valid && r[32]) begin x.Vk = r[31:0]; x.Qk_valid = 1'b0; end
        return x;
    endfunction

    task automatic idle();
        rst = 1'b0; flush = 1'b0; disp_valid = '0; cdb_valid = '0; rs_clear = '0;
    endtask

    // One clock: check the combinational stall, advance the model by the
    // specified rules, then compare every entry and the free count.
    task automatic do_cycle();
        AddSub_RS_Entry_t nx [NRS];
        int freeq[$];
        int nreq;
        logic go;
        logic [EW-1:0] a, b;
        int nfree;
        @(negedge clk);
        nreq = 0;
        for (int s = 0; s < DW; s++) if (disp_valid[s]) nreq++;
        freeq = {};
        for (int e = 0; e < NRS; e++) if (!m[e].busy) freeq.push_back(e);
        if (!rst) chk("disp_stall", 128'(disp_stall), 128'(nreq > freeq.size()));
        go = (nreq <= freeq.size()) && !flush && !rst;
        for (int e = 0; e < NRS; e++) nx[e] = m[e].busy ? wake(m[e]) : m[e];
        if (go) begin
            for (int s = 0; s < nreq; s++) begin
                nx[freeq[s]] = wake(disp_entry[s]);
                nx[freeq[s]].busy = 1'b1;
            end
        end
        for (int e = 0; e < NRS; e++) begin
            if (rs_clear[e] && m[e].busy) nx[e].busy = 1'b0;
            nx[e].ready = nx[e].busy && !nx[e].Qj_valid && !nx[e].Qk_valid;
            if (flush || rst) nx[e] = '0;
        end
        m = nx;
        @(posedge clk);
        #1;
        nfree = 0;
        for (int e = 0; e < NRS; e++) begin
            a = rs_out[e];
            b = m[e];
            chk($sformatf("rs_out[%0d]", e), 128'(a), 128'(b));
            if (!m[e].busy) nfree++;
        end
        chk("free_cnt", 128'(free_cnt), 128'(nfree));
    endtask

    function automatic logic [NRS-1:0] busy_vec();
        logic [NRS-1:0] v;
        for (int e = 0; e < NRS; e++) v[e] = rs_out[e].busy;
        return v;
    endfunction

    initial begin
        for (int e = 0; e < NRS; e++) m[e] = '0;
        idle();
        disp_entry = '0; cdb_tag = '0; cdb_data = '0;

        // Reset held two cycles.
        rst = 1'b1;
        do_cycle();
        do_cycle();
        idle();
        #1;
        chk("t1_busy", 128'(busy_vec()), 128'(0));
        chk("t1_free", 128'(free_cnt), 128'(8));
        chk("t1_stall", 128'(disp_stall), 128'(0));

        // Three ready ops into an empty bank.
        disp_entry[0] = mk(5'd1, 1'b0, 5'd0, 1'b0, 5'd0, 32'h10, 32'h11);
        disp_entry[1] = mk(5'd2, 1'b0, 5'd0, 1'b0, 5'd0, 32'h20, 32'h21);
        disp_entry[2] = mk(5'd3, 1'b0, 5'd0, 1'b0, 5'd0, 32'h30, 32'h31);
        disp_valid = 3'b111;
        do_cycle();
        idle();
        chk("t2_busy_ready", 128'({rs_out[2].busy, rs_out[2].ready, rs_out[1].busy,
                                   rs_out[1].ready, rs_out[0].busy, rs_out[0].ready}), 128'(6'h3f));
        chk("t2_free", 128'(free_cnt), 128'(5));
        chk("t2_rob1", 128'(rs_out[1].ROB_index), 128'(2));

        // Entry 3 waits on tag 7, then wakes from bus 1.
        disp_entry[0] = mk(5'd4, 1'b1, 5'd7, 1'b0, 5'd0, 32'h0, 32'h44);
        disp_valid = 3'b001;
        do_cycle();
        idle();
        chk("t3_wait_ready", 128'({rs_out[3].ready, rs_out[3].Qj_valid}), 128'(2'b01));
        cdb_valid = 3'b010; cdb_tag[1] = 5'd7; cdb_data[1] = 32'hDEAD;
        do_cycle();
        idle();
        chk("t3_vj", 128'(rs_out[3].Vj), 128'(32'hDEAD));
        chk("t3_qj_ready", 128'({rs_out[3].Qj_valid, rs_out[3].ready}), 128'(2'b01));

        // Same-cycle bypass of Qk=4 into entry 4.
        disp_entry[0] = mk(5'd5, 1'b0, 5'd0, 1'b1, 5'd4, 32'h22, 32'h0);
        disp_valid = 3'b001;
        cdb_valid = 3'b001; cdb_tag[0] = 5'd4; cdb_data[0] = 32'h55;
        do_cycle();
        idle();
        chk("t4_vk", 128'(rs_out[4].Vk), 128'(32'h55));
        chk("t4_qk_ready", 128'({rs_out[4].busy, rs_out[4].Qk_valid, rs_out[4].ready}), 128'(3'b101));

        // Fill to six, then three requests stall while entry 0 is cleared.
        disp_entry[0] = mk(5'd6, 1'b0, 5'd0, 1'b0, 5'd0, 32'h66, 32'h67);
        disp_valid = 3'b001;
        do_cycle();
        idle();
        disp_entry[0] = mk(5'd7, 1'b1, 5'd9, 1'b0, 5'd0, 32'h0, 32'h77);
        disp_entry[1] = mk(5'd8, 1'b1, 5'd9, 1'b0, 5'd0, 32'h0, 32'h88);
        disp_entry[2] = mk(5'd9, 1'b1, 5'd9, 1'b0, 5'd0, 32'h0, 32'h99);
        disp_valid = 3'b111;
        rs_clear = 8'b0000_0001;
        #1;
        chk("t5_stall", 128'(disp_stall), 128'(1));
        do_cycle();
        rs_clear = '0;
        chk("t5_after_stall", 128'(busy_vec()), 128'(8'b0011_1110));
        chk("t5_free", 128'(free_cnt), 128'(3));
        #1;
        chk("t5_retry_stall", 128'(disp_stall), 128'(0));
        do_cycle();
        idle();
        chk("t5_robs", 128'({rs_out[7].ROB_index, rs_out[6].ROB_index, rs_out[0].ROB_index}),
            128'({5'd9, 5'd8, 5'd7}));
        chk("t5_full", 128'(free_cnt), 128'(0));

        // Down to five busy, then flush with a CDB match and a request pending.
        rs_clear = 8'b0000_0111;
        do_cycle();
        idle();
        chk("t6_five", 128'(free_cnt), 128'(3));
        flush = 1'b1;
        cdb_valid = 3'b001; cdb_tag[0] = 5'd9; cdb_data[0] = 32'h99;
        disp_entry[0] = mk(5'd10, 1'b0, 5'd0, 1'b0, 5'd0, 32'h1, 32'h2);
        disp_valid = 3'b001;
        do_cycle();
        idle();
        chk("t6_busy", 128'(busy_vec()), 128'(0));
        chk("t6_free", 128'(free_cnt), 128'(8));
        chk("t6_entry0", 128'(rs_out[0].ROB_index), 128'(0));

        // Randomised traffic with occasional flush and mid-run reset.
        for (int cyc = 0; cyc < 3000; cyc++) begin
            int n;
            logic [4:0] t;
            logic ok;
            rst   = ($urandom_range(0, 199) == 0);
            flush = ($urandom_range(0, 39) == 0);
            n = $urandom_range(0, DW);
            disp_valid = DW'((1 << n) - 1);
            for (int s = 0; s < DW; s++) begin
                disp_entry[s] = mk(5'($urandom), 1'($urandom), 5'($urandom_range(0, 7)),
                                   1'($urandom), 5'($urandom_range(0, 7)), $urandom, $urandom);
                disp_entry[s].busy  = 1'($urandom);
                disp_entry[s].ready = 1'($urandom);
            end
            for (int b = 0; b < CDB_W; b++) begin
                cdb_valid[b] = 1'($urandom);
                cdb_data[b]  = $urandom;
                do begin
                    t = 5'($urandom_range(0, 7));
                    ok = 1'b1;
                    for (int p = 0; p < b; p++) if (cdb_valid[p] && cdb_tag[p] == t) ok = 1'b0;
                end while (!ok);
                cdb_tag[b] = t;
            end
            for (int e = 0; e < NRS; e++) rs_clear[e] = m[e].busy && ($urandom_range(0, 3) == 0);
            do_cycle();
        end
        idle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
